// File: rtl/gp_reg_bank.sv
// General-purpose register bank: one write port, two registered read ports
// (A and B) and a one-hot selected, registered bus output with a sticky
// contention flag.
//
// Handshake: there is none. wr_en is a plain strobe sampled on each rising
// edge. Every read address and bus_sel is sampled on every edge, and its
// result is visible on the matching output one cycle later. No back-pressure
// exists, so every port can be used every cycle.
module gp_reg_bank #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int AW      = $clog2(NREGS),
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic             ba_out,
  input  logic [NREGS-1:0] bus_sel,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  // Register contents as seen by the readers this cycle, including the
  // in-flight write when forwarding is enabled.
  logic [WIDTH-1:0] view   [NREGS];

  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bus_mux;
  logic             contention;

  // Next-state for the register file: only the addressed entry changes.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Reader view of each register, forwarding the same-cycle write if enabled.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      view[i] = regs_q[i];
      if ((BYPASS != 0) && wr_en && (wr_addr == AW'(i))) begin
        view[i] = wr_data;
      end
    end
  end

  // Read ports; port A returns zero for R0 in base-address mode.
  always_comb begin
    rd_a_d = view[rd_addr_a];
    rd_b_d = view[rd_addr_b];
    if ((ZERO_R0 != 0) && ba_out && (rd_addr_a == '0)) begin
      rd_a_d = '0;
    end
  end

  // Bus source select: OR of selected views, forced to zero on contention.
  always_comb begin
    bus_mux    = '0;
    contention = |(bus_sel & (bus_sel - NREGS'(1)));
    for (int i = 0; i < NREGS; i++) begin
      if (bus_sel[i]) begin
        bus_mux = bus_mux | view[i];
      end
    end
    bus_d = contention ? '0 : bus_mux;
    // A new contention beats a simultaneous clear request.
    if (contention) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous active-low clear taking priority.
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_a_q <= '0;
      rd_b_q <= '0;
      bus_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      bus_q  <= bus_d;
      err_q  <= err_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign bus_out   = bus_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_gp_reg_bank.sv
// Bench for gp_reg_bank: a default instance, a no-bypass/no-zeroing instance
// sharing the same inputs, and a small 8-bit x 4 instance.
module tb_gp_reg_bank;

  logic        clock = 1'b0;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic        ba_out;
  logic [15:0] bus_sel;
  logic        err_clr;

  logic [31:0] a0, b0, bus0, a1, b1, bus1;
  logic        err0, err1;

  logic       s_wr_en;
  logic [1:0] s_wr_addr, s_rd_a, s_rd_b;
  logic [7:0] s_wr_data;
  logic [3:0] s_bus_sel;
  logic [7:0] s_a, s_b, s_bus;
  logic       s_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: register contents and the sticky error flag.
  logic [31:0] m [16];
  logic        m_err;

  always #5 clock = ~clock;

  gp_reg_bank dut0 (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .ba_out(ba_out), .bus_sel(bus_sel), .err_clr(err_clr),
    .rd_data_a(a0), .rd_data_b(b0), .bus_out(bus0), .bus_err(err0)
  );

  gp_reg_bank #(.ZERO_R0(0), .BYPASS(0)) dut1 (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .ba_out(ba_out), .bus_sel(bus_sel), .err_clr(err_clr),
    .rd_data_a(a1), .rd_data_b(b1), .bus_out(bus1), .bus_err(err1)
  );

  gp_reg_bank #(.WIDTH(8), .NREGS(4)) dut2 (
    .clock(clock), .clear(clear), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .rd_addr_a(s_rd_a), .rd_addr_b(s_rd_b),
    .ba_out(1'b0), .bus_sel(s_bus_sel), .err_clr(1'b0),
    .rd_data_a(s_a), .rd_data_b(s_b), .bus_out(s_bus), .bus_err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a reader sees for register a, with or without write forwarding.
  function automatic logic [31:0] look(input int a, input bit byp);
    if (byp && wr_en && (int'(wr_addr) == a)) return wr_data;
    return m[a];
  endfunction

  task automatic idle();
    clear = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; ba_out = 1'b0; bus_sel = '0; err_clr = 1'b0;
  endtask

  // One clock: predict from the current inputs, advance, compare, update model.
  task automatic tick();
    logic [31:0] ea0, ea1, eb0, eb1, ebus0, ebus1;
    logic        eerr;
    int          n, idx;
    n = $countones(bus_sel);
    idx = 0;
    for (int i = 0; i < 16; i++) if (bus_sel[i]) idx = i;
    if (!clear) begin
      ea0 = 0; ea1 = 0; eb0 = 0; eb1 = 0; ebus0 = 0; ebus1 = 0; eerr = 1'b0;
    end else begin
      ea0   = (ba_out && rd_addr_a == 0) ? 32'h0 : look(int'(rd_addr_a), 1'b1);
      ea1   = look(int'(rd_addr_a), 1'b0);
      eb0   = look(int'(rd_addr_b), 1'b1);
      eb1   = look(int'(rd_addr_b), 1'b0);
      ebus0 = (n == 1) ? look(idx, 1'b1) : 32'h0;
      ebus1 = (n == 1) ? look(idx, 1'b0) : 32'h0;
      eerr  = (n >= 2) ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
    if (!clear) begin
      for (int i = 0; i < 16; i++) m[i] = 32'h0;
    end else if (wr_en) begin
      m[wr_addr] = wr_data;
    end
    m_err = eerr;
    @(posedge clock);
    #1;
    chk("rd_a_byp", a0, ea0);
    chk("rd_b_byp", b0, eb0);
    chk("bus_byp", bus0, ebus0);
    chk("err_byp", {31'h0, err0}, {31'h0, eerr});
    chk("rd_a_nobyp", a1, ea1);
    chk("rd_b_nobyp", b1, eb1);
    chk("bus_nobyp", bus1, ebus1);
    chk("err_nobyp", {31'h0, err1}, {31'h0, eerr});
  endtask

  initial begin
    idle();
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_a = '0; s_rd_b = '0; s_bus_sel = '0;
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    m_err = 1'b0;

    // Reset with write and error-clear activity that must be discarded.
    clear = 1'b0; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h1111_2222; bus_sel = 16'h0003;
    tick();
    chk("reset_rd_a", a0, 32'h0);
    chk("reset_bus_err", {31'h0, err0}, 32'h0);
    chk("small_reset_rd_a", {24'h0, s_a}, 32'h0);
    idle();

    // Basic write then read of R0/R1.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEAD_BEEF; tick();
    wr_addr = 4'd1; wr_data = 32'hFACE_CAFE; tick();
    wr_en = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd1; tick();
    chk("basic_rd_a", a0, 32'hDEAD_BEEF);
    chk("basic_rd_b", b0, 32'hFACE_CAFE);

    // Same-cycle write/read of R5.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1234_5678; rd_addr_a = 4'd5; tick();
    chk("bypass_on", a0, 32'h1234_5678);
    chk("bypass_off", a1, 32'h0);
    idle();

    // Base-address mode on R0.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hCAFE_BABE; tick();
    wr_en = 1'b0; ba_out = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd0; tick();
    chk("baout_a_zero", a0, 32'h0);
    chk("baout_b_intact", b0, 32'hCAFE_BABE);
    chk("baout_ignored", a1, 32'hCAFE_BABE);
    ba_out = 1'b0; tick();
    chk("baout_off_a", a0, 32'hCAFE_BABE);

    // Bus selection, contention, sticky flag and clear priority.
    bus_sel = 16'h0002; tick();
    chk("bus_r1", bus0, 32'hFACE_CAFE);
    bus_sel = 16'h0003; tick();
    chk("bus_contention_zero", bus0, 32'h0);
    chk("bus_err_set", {31'h0, err0}, 32'h1);
    bus_sel = 16'h0000; tick();
    chk("bus_err_sticky", {31'h0, err0}, 32'h1);
    err_clr = 1'b1; tick();
    chk("bus_err_cleared", {31'h0, err0}, 32'h0);
    bus_sel = 16'h8001; tick();
    chk("bus_err_set_wins", {31'h0, err0}, 32'h1);
    bus_sel = 16'h0000; tick();
    err_clr = 1'b0;

    // Bus forwarding of a same-cycle write.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0BAD_F00D; bus_sel = 16'h0080; tick();
    chk("bus_bypass_on", bus0, 32'h0BAD_F00D);
    chk("bus_bypass_off", bus1, 32'h0);
    idle();

    // Randomised traffic against the model.
    for (int it = 0; it < 400; it++) begin
      int mode;
      clear   = ($urandom_range(0, 39) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rd_addr_b = rd_addr_a;
      ba_out  = $urandom_range(0, 1);
      mode    = $urandom_range(0, 4);
      case (mode)
        0: bus_sel = '0;
        1: bus_sel = 16'(1) << wr_addr;
        2, 3: bus_sel = 16'(1) << $urandom_range(0, 15);
        default: bus_sel = 16'($urandom);
      endcase
      err_clr = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    bus_sel = 16'h0000; err_clr = 1'b1; tick();
    err_clr = 1'b0;

    // Reset mid-operation; clear must not act before the edge.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h3333_3333; rd_addr_a = 4'd3; tick();
    chk("r3_written", a0, 32'h3333_3333);
    clear = 1'b0; wr_data = 32'h9999_9999;
    #2;
    chk("clear_not_async", a0, 32'h3333_3333);
    tick();
    chk("midreset_rd_a", a0, 32'h0);
    chk("midreset_bus", bus0, 32'h0);
    idle();
    rd_addr_a = 4'd3; tick();
    chk("r3_after_reset", a0, 32'h0);

    // Small instance: 8-bit, 4 registers.
    s_wr_en = 1'b1; s_wr_addr = 2'd3; s_wr_data = 8'hA5; tick();
    s_wr_en = 1'b0; s_rd_a = 2'd3; s_bus_sel = 4'b1000; tick();
    chk("small_rd_a", {24'h0, s_a}, 32'h0000_00A5);
    chk("small_bus", {24'h0, s_bus}, 32'h0000_00A5);
    chk("small_err", {31'h0, s_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gp_reg_bank.md
GP_REG_BANK -- requirements
Module: gp_reg_bank

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register and data port.
REQ-002 Parameter NREGS, default 16, register count; power of two, >= 2.
REQ-003 Parameter AW, default $clog2(NREGS), address width.
REQ-004 Parameter ZERO_R0, default 1; 1 enables BAout zeroing of R0.
REQ-005 Parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 clear  in  1  reset; synchronous, active-low.
REQ-008 wr_en  in  1  write strobe.
REQ-009 wr_addr  in  AW  write address.
REQ-010 wr_data  in  WIDTH  write data.
REQ-011 rd_addr_a / rd_addr_b  in  AW each  read-port addresses.
REQ-012 ba_out  in  1  base-address read mode for port A.
REQ-013 bus_sel  in  NREGS  one-hot bus source select, bit i = Ri.
REQ-014 rd_data_a / rd_data_b  out  WIDTH each  registered read data.
REQ-015 bus_out  out  WIDTH  registered bus value.
REQ-016 bus_err  out  1  sticky bus-contention flag.
REQ-017 err_clr  in  1  clears bus_err.

Function
REQ-018 Write: on a rising edge with clear=1 and wr_en=1, R[wr_addr] SHALL take wr_data; wr_en=0 leaves all registers unchanged.
REQ-019 Read latency SHALL be 1 cycle: rd_data_x at edge n+1 reflects rd_addr_x sampled at edge n.
REQ-020 BYPASS=1 with wr_en=1 and rd_addr_x==wr_addr in the same cycle: rd_data_x SHALL return wr_data, not the old value.
REQ-021 BYPASS=0 in the same case: rd_data_x SHALL return the pre-write value.
REQ-022 ZERO_R0=1, ba_out=1, rd_addr_a==0: rd_data_a SHALL load 0 regardless of R0 contents or bypass.
REQ-023 Port B SHALL NOT be affected by ba_out.
REQ-024 ZERO_R0=0: ba_out SHALL be ignored.
REQ-025 Bus, zero bits set in bus_sel: bus_out SHALL load 0 on the next edge.
REQ-026 Bus, exactly one bit i set: bus_out SHALL load R[i] on the next edge.
REQ-027 Bus select SHALL honour the same bypass rule as the read ports, per BYPASS.
REQ-028 Bus, two or more bits set: bus_out SHALL load 0 and bus_err SHALL set on the next edge.
REQ-029 bus_err SHALL remain set until an edge with err_clr=1 and no contention.
REQ-030 Contention and err_clr in the same cycle: set SHALL win.
REQ-031 Both read ports and the bus SHALL be usable every cycle, with any address combination including all equal.
REQ-032 Address range is 0..NREGS-1; no out-of-range case exists.

Reset
REQ-033 Edge with clear=0: all NREGS registers, rd_data_a, rd_data_b and bus_out SHALL become 0, and bus_err SHALL become 0.
REQ-034 Reset SHALL take priority over any simultaneous wr_en, bus_sel or err_clr activity; that write is discarded.
REQ-035 clear SHALL have no asynchronous effect: outputs hold until the next rising edge.

Verification
REQ-036 Reset then write R0=0xDEADBEEF, R1=0xFACECAFE; read A=0, B=1 -> rd_data_a=0xDEADBEEF, rd_data_b=0xFACECAFE one cycle later.
REQ-037 Bypass: wr_en=1, wr_addr=5, wr_data=0x12345678, rd_addr_a=5 same cycle -> BYPASS=1 gives 0x12345678 next cycle; BYPASS=0 gives the old value (0 after reset).
REQ-038 BAout: R0=0xCAFEBABE, ba_out=1, rd_addr_a=0, rd_addr_b=0 -> rd_data_a=0, rd_data_b=0xCAFEBABE; repeat with ba_out=0 -> rd_data_a=0xCAFEBABE.
REQ-039 Bus: bus_sel=0x0002 -> bus_out=0xFACECAFE; bus_sel=0x0003 -> bus_out=0, bus_err=1; bus_sel=0 with err_clr=1 -> bus_err=0 next edge; contention plus err_clr in the same cycle -> bus_err stays 1.
REQ-040 Reset mid-operation: clear=0 together with wr_en=1 to R3 -> next cycle all outputs 0; subsequent read of R3 returns 0.
REQ-041 Parameter sweep: WIDTH=8, NREGS=4 -> write 0xA5 to R3, read back 0xA5; bus_sel=4'b1000 -> bus_out=0xA5.
